// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned INSTR_W  = 16;
  // FIFO entries carry a PC wide enough for any supported ADDR_WIDTH (<= 32).
  localparam int unsigned PC_W_MAX = 32;

  localparam logic [PC_W_MAX-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port plus decode-side handshake, redirect and halt.
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import ifetch_pkg::*;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_en;
  logic                  imem_wr;
  logic [INSTR_W-1:0]    imem_data_in;
  logic [INSTR_W-1:0]    imem_data_out;
  logic [INSTR_W-1:0]    instr_out;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  halted;

  modport master (
    output imem_addr, imem_en, imem_wr, imem_data_in, instr_out, pc_out, instr_valid, halted,
    input  imem_data_out, instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_addr, imem_en, imem_wr, imem_data_in, instr_out, pc_out, instr_valid, halted,
    output imem_data_out, instr_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; push and pop together are legal even when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When full, wr_ptr equals rd_ptr: the write lands in the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, halt/redirect control and prefetch buffering.
// Define IFETCH_BYPASS_EN to forward memory data straight to decode when the FIFO is empty.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter int unsigned          DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);

  localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  halted_q, halted_d;
  logic [CNT_W-1:0]      count;
  fetch_entry_t          head, mem_entry, out_entry;
  logic                  issue, bypass, fifo_push, fifo_pop;
  logic                  unused_bits;

  // A full FIFO is always valid, so instr_ready alone tells whether a slot frees up.
  assign issue = ~rst & ~bus.redirect & ~bus.halt & ~halted_q
               & ((count != FULL_CNT) | bus.instr_ready);

  assign mem_entry = '{pc: PC_W_MAX'(fetch_pc_q), instr: bus.imem_data_out};

`ifdef IFETCH_BYPASS_EN
  assign bypass = issue & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_entry = bypass ? mem_entry : head;
  assign fifo_push = issue & ~(bypass & bus.instr_ready);
  assign fifo_pop  = bus.instr_ready & (count != '0);

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (fifo_push),
    .push_data (mem_entry),
    .pop       (fifo_pop),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      halted_d   = 1'b0;
    end else begin
      if (issue)    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(2);
      if (bus.halt) halted_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_addr    = fetch_pc_q;
  assign bus.imem_en      = issue;
  assign bus.imem_wr      = 1'b0;
  assign bus.imem_data_in = '0;
  assign bus.instr_out    = out_entry.instr;
  assign bus.pc_out       = out_entry.pc[ADDR_WIDTH-1:0];
  assign bus.instr_valid  = (count != '0) | bypass;
  assign bus.halted       = halted_q;

  assign unused_bits = ^{out_entry.pc, bus.redirect_pc[0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a reference PC/FIFO model feeds a scoreboard queue.
module tb_instr_fetch;
  import ifetch_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 2;
  localparam logic [15:0] RPC   = 16'h0000;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  logic [15:0] m_pc = RPC;
  logic        m_halted = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      default:  return a ^ 16'hC3A5;
    endcase
  endfunction

  always_comb bus.imem_data_out = mem_word(bus.imem_addr);

  // Reference model: predicts issue, tracks expected FIFO contents, checks every cycle.
  always @(negedge clk) begin
    bit exp_en, exp_valid;
    int n_before;
    if (rst) begin
      n_checks++;
      if (bus.imem_en !== 1'b0) $display("FAIL mon_rst_en: got %b want 0", bus.imem_en);
      else n_pass++;
      q.delete();
      m_pc     = RPC;
      m_halted = 1'b0;
    end else begin
      n_before = q.size();
      exp_en = !bus.redirect && !bus.halt && !m_halted
               && (n_before < DEPTH || bus.instr_ready);
      n_checks++;
      if (bus.imem_en !== exp_en)
        $display("FAIL mon_en: got %b want %b at %0t", bus.imem_en, exp_en, $time);
      else n_pass++;
      n_checks++;
      if (bus.halted !== m_halted)
        $display("FAIL mon_halted: got %b want %b at %0t", bus.halted, m_halted, $time);
      else n_pass++;
      if (exp_en) begin
        n_checks++;
        if (bus.imem_addr !== m_pc)
          $display("FAIL mon_addr: got %h want %h at %0t", bus.imem_addr, m_pc, $time);
        else n_pass++;
        q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 16'd2;
      end
      exp_valid = (LAT == 0) ? (q.size() != 0) : (n_before != 0);
      n_checks++;
      if (bus.instr_valid !== exp_valid)
        $display("FAIL mon_valid: got %b want %b at %0t", bus.instr_valid, exp_valid, $time);
      else n_pass++;
      if (exp_valid && q.size() != 0) begin
        n_checks++;
        if (bus.pc_out !== q[0].pc || bus.instr_out !== q[0].instr)
          $display("FAIL mon_out: got %h/%h want %h/%h at %0t",
                   bus.pc_out, bus.instr_out, q[0].pc, q[0].instr, $time);
        else n_pass++;
        if (bus.instr_ready) void'(q.pop_front());
      end
      if (bus.redirect) begin
        q.delete();
        m_pc     = bus.redirect_pc & 16'hFFFE;
        m_halted = 1'b0;
      end else if (bus.halt) begin
        m_halted = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0 || bus.pc_out !== 16'h0)
      $display("FAIL reset_out: got v=%b i=%h pc=%h want 0/0000/0000",
               bus.instr_valid, bus.instr_out, bus.pc_out);
    else n_pass++;
    n_checks++;
    if (bus.halted !== 1'b0 || bus.imem_en !== 1'b0 || bus.imem_wr !== 1'b0)
      $display("FAIL reset_ctl: got halted=%b en=%b wr=%b want 0/0/0",
               bus.halted, bus.imem_en, bus.imem_wr);
    else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    logic [15:0] exp_instr [3];
    exp_instr = '{16'h1111, 16'h2222, 16'h3333};
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== RPC)
          $display("FAIL stream_first_fetch: got en=%b addr=%h want 1/%h",
                   bus.imem_en, bus.imem_addr, RPC);
        else n_pass++;
      end
      if (c >= LAT) begin
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== 16'(2 * (c - LAT))
            || bus.instr_out !== exp_instr[c - LAT])
          $display("FAIL stream_out%0d: got v=%b pc=%h i=%h want 1/%h/%h", c - LAT,
                   bus.instr_valid, bus.pc_out, bus.instr_out, 16'(2 * (c - LAT)),
                   exp_instr[c - LAT]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    n_checks++;
    if (bus.imem_en !== 1'b0 || bus.imem_addr !== 16'h0004 || bus.instr_valid !== 1'b1
        || bus.pc_out !== 16'h0000)
      $display("FAIL stall_full: got en=%b addr=%h v=%b pc=%h want 0/0004/1/0000",
               bus.imem_en, bus.imem_addr, bus.instr_valid, bus.pc_out);
    else n_pass++;
    tick();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.pc_out !== 16'(2 * i))
        $display("FAIL stall_release%0d: got v=%b pc=%h want 1/%h",
                 i, bus.instr_valid, bus.pc_out, 16'(2 * i));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0041;
    @(negedge clk);
    n_checks++;
    if (bus.imem_en !== 1'b0) $display("FAIL redir_en: got %b want 0", bus.imem_en);
    else n_pass++;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.instr_valid !== (LAT == 0))
      $display("FAIL redir_fetch: got en=%b addr=%h v=%b want 1/0040/%b",
               bus.imem_en, bus.imem_addr, bus.instr_valid, LAT == 0);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc_out !== 16'h0040
        || bus.instr_out !== mem_word(16'h0040))
      $display("FAIL redir_out: got v=%b pc=%h i=%h want 1/0040/%h",
               bus.instr_valid, bus.pc_out, bus.instr_out, mem_word(16'h0040));
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [3];
    exp_pc = '{16'hFFFC, 16'hFFFE, 16'h0000};
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFC;
    tick();
    bus.redirect = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        n_checks++;
        if (bus.instr_valid !== 1'b1 || bus.pc_out !== exp_pc[c - LAT])
          $display("FAIL wrap_pc%0d: got v=%b pc=%h want 1/%h",
                   c - LAT, bus.instr_valid, bus.pc_out, exp_pc[c - LAT]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_halt();
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    bus.halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.imem_en !== 1'b0) $display("FAIL halt_en: got %b want 0", bus.imem_en);
    else n_pass++;
    tick();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.halted !== 1'b1 || bus.imem_en !== 1'b0 || bus.instr_valid !== (i < 2))
        $display("FAIL halt_drain%0d: got halted=%b en=%b v=%b want 1/0/%b",
                 i, bus.halted, bus.imem_en, bus.instr_valid, i < 2);
      else n_pass++;
      tick();
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.halt     = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.halted !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0100)
      $display("FAIL halt_resume: got halted=%b en=%b addr=%h want 0/1/0100",
               bus.halted, bus.imem_en, bus.imem_addr);
    else n_pass++;
    tick();
  endtask

  task automatic test_rst_mid();
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1) $display("FAIL rstmid_pre: got v=%b want 1", bus.instr_valid);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0)
      $display("FAIL rstmid_clear: got v=%b en=%b want 0/0", bus.instr_valid, bus.imem_en);
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== RPC)
      $display("FAIL rstmid_restart: got en=%b addr=%h want 1/%h",
               bus.imem_en, bus.imem_addr, RPC);
    else n_pass++;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_rst_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
